// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with Mealy/Moore outputs and a saturating counter.
// Optional SEQ_DET_COUNT_CLR_EN adds a synchronous count_clr input.
module seq_detector_param #(
  parameter int unsigned         MAX_LEN     = 8,
  parameter int unsigned         CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int unsigned         DEF_LEN     = 4,
  parameter bit                  DEF_OVERLAP = 1'b1,
  localparam int unsigned        LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
`ifdef SEQ_DET_COUNT_CLR_EN
  input  logic               count_clr,
`endif
  output logic               mealy_detected,
  output logic               moore_detected,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] history_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic               moore_q;
  logic [CNT_W-1:0]   count_q;

  logic               accept;
  logic               fill_ok;
  logic               match;
  logic               count_clr_int;
  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_clamped;

`ifdef SEQ_DET_COUNT_CLR_EN
  assign count_clr_int = count_clr;
`else
  assign count_clr_int = 1'b0;
`endif

  assign accept  = in_valid & ~cfg_load;
  assign shifted = {history_q[MAX_LEN-2:0], in};

  // Only the low len_q bits of history and pattern take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (32'(i) < 32'(len_q));
    end
  end

  assign fill_ok = ((LEN_W + 1)'(fill_q) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(len_q);

  assign match = accept & ~rst & fill_ok & (len_q != '0) &
                 ((shifted & mask) == (pattern_q & mask));

  assign fill_inc    = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
  assign len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history_q <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      moore_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      moore_q <= match;
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        len_q     <= len_clamped;
        overlap_q <= cfg_overlap;
        history_q <= '0;
        fill_q    <= '0;
      end else if (accept) begin
        history_q <= shifted;
        // Non-overlap mode restarts the fill so the next match needs len fresh bits.
        fill_q    <= (match && !overlap_q) ? '0 : fill_inc;
      end
      if (count_clr_int) begin
        count_q <= match ? CNT_W'(1) : '0;
      end else if (match && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign mealy_detected = match;
  assign moore_detected = moore_q;
  assign match_count    = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a bit-queue reference model predicts every cycle.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in = 1'b0;
  logic               in_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               count_clr = 1'b0;
  logic               mealy_detected;
  logic               moore_detected;
  logic [CNT_W-1:0]   match_count;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in             (in),
    .in_valid       (in_valid),
    .cfg_load       (cfg_load),
    .cfg_pattern    (cfg_pattern),
    .cfg_len        (cfg_len),
    .cfg_overlap    (cfg_overlap),
`ifdef SEQ_DET_COUNT_CLR_EN
    .count_clr      (count_clr),
`endif
    .mealy_detected (mealy_detected),
    .moore_detected (moore_detected),
    .match_count    (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mealy;
    bit moore;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model: bits received since the last restart, oldest first.
  bit               m_bits[$];
  logic [MAX_LEN-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  int               m_cnt;
  bit               m_prev;

  task automatic model_reset();
    m_bits.delete();
    m_pat  = 8'b0000_1011;
    m_len  = 4;
    m_ovl  = 1'b1;
    m_cnt  = 0;
    m_prev = 1'b0;
  endtask

  // One clock cycle: drive inputs just after the edge, record what the DUT should show.
  task automatic cycle(input bit r, input bit v, input bit b, input bit ld, input bit clr);
    exp_t e;
    bit   hit;
    int   sz;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in = b; cfg_load = ld; count_clr = clr;
    if (r) begin
      model_reset();
      e.mealy = 1'b0; e.moore = 1'b0; e.cnt = 0;
    end else begin
      hit = 1'b0;
      if (v && !ld) begin
        m_bits.push_back(b);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        sz = m_bits.size();
        if (m_len != 0 && sz >= m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (m_bits[sz - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
        end
      end
      e.mealy = hit; e.moore = m_prev; e.cnt = m_cnt;
      if (ld) begin
        m_pat = cfg_pattern;
        m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
        m_ovl = cfg_overlap;
        m_bits.delete();
      end else if (hit && !m_ovl) begin
        m_bits.delete();
      end
`ifdef SEQ_DET_COUNT_CLR_EN
      if (clr) m_cnt = hit ? 1 : 0;
      else
`endif
      if (hit && m_cnt < CNT_MAX) m_cnt++;
      m_prev = hit;
    end
    q.push_back(e);
  endtask

  task automatic send(input bit b);
    cycle(1'b0, 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input int len, input bit ovl, input bit b);
    cfg_pattern = p; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    cycle(1'b0, 1'b1, b, 1'b1, 1'b0);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("mealy_detected", int'(mealy_detected), int'(e.mealy));
        check("moore_detected", int'(moore_detected), int'(e.moore));
        check("match_count", int'(match_count), e.cnt);
      end
    end
  end

  initial begin : stim
    logic [7:0] seq_a;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Default 1011 with overlap: matches on bits 4 and 7.
    seq_a = 8'b1011_0110;
    for (int i = 7; i >= 1; i--) send(seq_a[i]);
    idle(2);

    // 111 with and without overlap.
    load(8'b0000_0111, 3, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) send(1'b1);
    load(8'b0000_0111, 3, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(1'b1);

    // 1011 with valid gaps.
    load(8'b0000_1011, 4, 1'b1, 1'b0);
    seq_a = 8'b0000_1011;
    for (int i = 3; i >= 0; i--) begin
      send(seq_a[i]);
      idle($urandom_range(1, 3));
    end

    // Load mid-pattern discards the in-flight bit and the partial match.
    send(1'b1); send(1'b0); send(1'b1);
    load(8'b0000_1011, 4, 1'b1, 1'b1);
    send(1'b1);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);

    // Saturation with 11 overlap, then clear pulses.
    load(8'b0000_0011, 2, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) send(1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b1); send(1'b1);

    // Reset after partial 101 loses it.
    load(8'b0000_1011, 4, 1'b1, 1'b0);
    send(1'b1); send(1'b0); send(1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);

    // Length 0 disables; length above MAX_LEN clamps.
    load(8'b0000_0000, 0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) send(i[0]);
    load(8'b1111_1111, 12, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send(1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      int k;
      k = $urandom_range(0, 299);
      if (k == 0) begin
        cycle(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
      end else if (k < 8) begin
        int len;
        len = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4) : $urandom_range(0, 10);
        load(MAX_LEN'($urandom), len, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        cycle(1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 1'b0,
              $urandom_range(0, 49) == 0);
      end
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
